// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and accumulator word type for the MAC cell.
package mac_pkg;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/mac_mul.sv
// mac_mul: unsigned full-width combinational multiplier.
module mac_mul import mac_pkg::*; #(
    parameter int DATA_W = mac_pkg::DATA_W
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);
    assign p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
endmodule

// File: rtl/mac_cell.sv
// mac_cell: systolic multiply-accumulate cell, acc_out <= acc_in + a*b each clock.
module mac_cell import mac_pkg::*; #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);
    if (ACC_W < 2*DATA_W || DATA_W < 1) begin : g_bad_widths
        $error("mac_cell: need DATA_W >= 1 and ACC_W >= 2*DATA_W");
    end
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_d, acc_q;
    mac_mul #(.DATA_W(DATA_W)) u_mul (.a(a), .b(b), .p(prod));
    // Product is zero-extended; the add wraps modulo 2^ACC_W.
    assign acc_d = acc_in + ACC_W'(prod);
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
    assign acc_out = acc_q;
endmodule

// File: tb/tb_mac_cell.sv
// tb_mac_cell: scoreboard bench, directed cases plus random and feedback streams.
module tb_mac_cell;
    import mac_pkg::*;

    typedef struct {
        string name;
        acc_t  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    acc_t        acc_in, acc_out;
    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    mac_cell dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .acc_in(acc_in), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    function automatic acc_t model(input logic [15:0] ma, input logic [15:0] mb, input acc_t ci);
        longint unsigned s;
        s = longint'(ma) * longint'(mb) + longint'(ci);
        return acc_t'(s % (64'd1 << 32));
    endfunction

    task automatic drive(input string n, input logic r, input logic [15:0] ta,
                         input logic [15:0] tb_, input acc_t ci, input acc_t ev);
        @(negedge clk);
        rst = r; a = ta; b = tb_; acc_in = ci;
        q.push_back('{n, ev});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_checks++;
                if (acc_out !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: acc_out=%h expected=%h", e.name, acc_out, e.v);
                end
            end
        end
    end

    initial begin
        acc_t        run;
        logic [15:0] ra, rb;
        acc_t        rc;
        logic        rr;
        rst = 1'b1; a = '0; b = '0; acc_in = '0;
        drive("reset", 1'b1, 16'd0, 16'd0, 32'd0, 32'd0);
        drive("basic", 1'b0, 16'd3, 16'd4, 32'd10, 32'd22);
        drive("hold", 1'b0, 16'd3, 16'd4, 32'd10, 32'd22);
        drive("chain", 1'b0, 16'd2, 16'd5, 32'd22, 32'd32);
        drive("width", 1'b0, 16'hFFFF, 16'hFFFF, 32'd0, 32'hFFFE0001);
        drive("wrap", 1'b0, 16'hFFFF, 16'hFFFF, 32'h0001FFFF, 32'h00000000);
        drive("max_wrap", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFE0000);
        drive("mid_reset", 1'b1, 16'd7, 16'd7, 32'd1, 32'd0);
        drive("post_reset", 1'b0, 16'd7, 16'd7, 32'd1, 32'd50);
        drive("reset_busy", 1'b1, 16'hFFFF, 16'h1234, 32'hDEADBEEF, 32'd0);
        drive("post_reset2", 1'b0, 16'd0, 16'd9, 32'h12345678, 32'h12345678);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = $urandom;
            rr = ($urandom_range(0, 39) == 0);
            drive("random", rr, ra, rb, rc, rr ? 32'd0 : model(ra, rb, rc));
        end
        run = '0;
        drive("fb_reset", 1'b1, 16'd0, 16'd0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive("feedback", 1'b0, ra, rb, run, model(ra, rb, run));
            run = model(ra, rb, run);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_cell.md
MAC_CELL -- requirements
Module: mac_cell

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W SHALL default to 16 and set the width of operands a and b.
REQ-003 Parameter ACC_W SHALL default to 32 and set the width of acc_in and acc_out.
REQ-004 Ports SHALL be:
- clk, input, 1 bit: sole clock, rising edge active.
- rst, input, 1 bit: synchronous, active-high reset.
- a, input, DATA_W bits: multiplicand.
- b, input, DATA_W bits: multiplier.
- acc_in, input, ACC_W bits: partial sum from the upstream cell.
- acc_out, output, ACC_W bits: registered partial sum to the downstream cell.
REQ-005 There SHALL be no other ports and no valid/ready handshake; a new operation is accepted every clock.

Function
REQ-006 On each rising clk edge with rst=0, acc_out SHALL load acc_in + a*b, sampled at that same edge.
REQ-007 Latency SHALL be exactly one clock from input sampling to acc_out update; throughput SHALL be one result per clock.
REQ-008 Operands and accumulator SHALL be unsigned.
REQ-009 The product a*b SHALL be computed at full 2*DATA_W width.
REQ-010 The product SHALL be zero-extended (or truncated to its low ACC_W bits) to ACC_W before the add.
REQ-011 The sum SHALL wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-012 acc_out SHALL be driven directly from a flop, with no combinational path from any input to acc_out.
REQ-013 acc_out SHALL hold its value only if inputs are unchanged (the cell has no enable); it SHALL NOT self-accumulate.
REQ-014 Feedback use (acc_in tied to the previous acc_out) SHALL produce a running accumulation, one term per clock.
REQ-015 Elaboration SHALL fail if ACC_W < 2*DATA_W or DATA_W < 1.

Reset
REQ-016 While rst=1 at a rising edge, acc_out SHALL become 0 regardless of a, b and acc_in.
REQ-017 Reset asserted mid-stream SHALL discard the in-flight result; the first cycle after rst deasserts SHALL compute from inputs sampled at that edge.
REQ-018 acc_out SHALL be undefined only before the first reset edge; there SHALL be no asynchronous reset path.

Structure
REQ-019 DATA_W and ACC_W defaults SHALL live in the shared package mac_pkg as localparams, together with a typedef for the accumulator word.
REQ-020 The multiply SHALL be a separate combinational sub-module, mac_mul (inputs a and b, product output of 2*DATA_W bits), instantiated once.
REQ-021 The add and output register SHALL reside in mac_cell.
REQ-022 The cell SHALL be tileable into a systolic row by chaining acc_out to the next cell's acc_in.

Verification
REQ-023 Reset: rst=1 for one edge with a=b=acc_in=0 -> acc_out=0. Sample outputs after the edge settles, not in the same delta.
REQ-024 Basic: a=3, b=4, acc_in=10 -> acc_out=22 one edge later.
REQ-025 Chain: next cycle a=2, b=5, acc_in=22 (previous acc_out) -> acc_out=32.
REQ-026 Width/wrap: a=b=16'hFFFF with acc_in=0 -> 32'hFFFE0001; then acc_in=32'h0001FFFF -> 32'h00000000 (wrap).
REQ-027 Mid-stream reset: rst=1 with a=7, b=7, acc_in=1 -> acc_out=0; after rst deasserts with the same inputs -> 50.
REQ-028 Random: 1000 back-to-back random vectors checked against a one-cycle-delayed reference model, mod 2^32.
